// File: rtl/mac_tx_fmt_if.sv
// Stream-in / PCS-out signal bundle for mac_tx_fmt; s_err_i exists only when MAC_TX_FMT_ERR_EN is defined.
interface mac_tx_fmt_if;
   logic         s_valid_i;
   logic         s_ready_o;
   logic [255:0] s_data_i;
   logic [31:0]  s_keep_i;
   logic         s_last_i;
`ifdef MAC_TX_FMT_ERR_EN
   logic         s_err_i;
`endif
   logic         pcs_ready_i;
   logic [3:0]   ctrl_v_o;
   logic [3:0]   idle_v_o;
   logic [3:0]   start_v_o;
   logic [3:0]   term_v_o;
   logic [3:0]   err_v_o;
   logic [255:0] data_o;
   logic [31:0]  keep_o;

`ifdef MAC_TX_FMT_ERR_EN
   modport slave (
      input  s_valid_i, s_data_i, s_keep_i, s_last_i, s_err_i, pcs_ready_i,
      output s_ready_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, data_o, keep_o
   );
   modport master (
      output s_valid_i, s_data_i, s_keep_i, s_last_i, s_err_i, pcs_ready_i,
      input  s_ready_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, data_o, keep_o
   );
`else
   modport slave (
      input  s_valid_i, s_data_i, s_keep_i, s_last_i, pcs_ready_i,
      output s_ready_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, data_o, keep_o
   );
   modport master (
      output s_valid_i, s_data_i, s_keep_i, s_last_i, pcs_ready_i,
      input  s_ready_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, data_o, keep_o
   );
`endif
endinterface

// File: rtl/mac_tx_fmt.sv
// Frames 256b MAC beats into 4x64b PCS lane blocks (start/data/term/idle), one registered beat per pcs_ready_i cycle;
// holds everything while pcs_ready_i=0 and refuses input during TAIL/IPG. MAC_TX_FMT_ERR_EN adds s_err_i error marking.
module mac_tx_fmt #(
   parameter int unsigned IPG_BEATS = 1
) (
   input  logic       clk,
   input  logic       reset,
   mac_tx_fmt_if.slave bus
);
   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_DATA   = 2'd1;
   localparam logic [1:0]  ST_TAIL   = 2'd2;
   localparam logic [1:0]  ST_IPG    = 2'd3;
   localparam logic [63:0] START_BLK = 64'hD5555555555555FB;
   localparam logic [3:0]  IPG_LD    = 4'(IPG_BEATS);

   logic [1:0]   r_state;
   logic [3:0]   r_ipg_cnt;
   logic [63:0]  r_resid;
   logic [3:0]   r_tail_r;
   logic         r_err_tail;
   logic [3:0]   r_ctrl_v, r_idle_v, r_start_v, r_term_v, r_err_v;
   logic [255:0] r_data;
   logic [31:0]  r_keep;

   logic         w_accept, w_in_err;
   logic [5:0]   w_t, w_tv;
   logic [255:0] w_src;
   logic         w_has_term, w_lane0_start, w_err;
   logic [1:0]   w_nxt_state;
   logic [3:0]   w_nxt_cnt, w_nxt_tail_r;
   logic [63:0]  w_nxt_resid;
   logic         w_nxt_err_tail;
   logic [3:0]   w_ctrl_v, w_idle_v, w_start_v, w_term_v, w_err_v;
   logic [255:0] w_data;
   logic [31:0]  w_keep;
   logic [7:0]   w_lkeep;

`ifdef MAC_TX_FMT_ERR_EN
   assign w_in_err = bus.s_err_i;
`else
   assign w_in_err = 1'b0;
`endif

   assign bus.s_ready_o = bus.pcs_ready_i & ((r_state == ST_IDLE) | (r_state == ST_DATA)) & ~reset;
   assign w_accept      = bus.s_valid_i & bus.s_ready_o;
   assign w_t           = 6'd8 + 6'($countones(bus.s_keep_i));

   // w_src/w_tv describe the beat: lane payload plus how many bytes from lane0 are valid before a terminate.
   always_comb begin
      w_src          = '0;
      w_tv           = '0;
      w_has_term     = 1'b0;
      w_lane0_start  = 1'b0;
      w_err          = 1'b0;
      w_nxt_state    = r_state;
      w_nxt_cnt      = r_ipg_cnt;
      w_nxt_resid    = r_resid;
      w_nxt_tail_r   = r_tail_r;
      w_nxt_err_tail = r_err_tail;
      case (r_state)
         ST_IDLE, ST_DATA: begin
            if (w_accept) begin
               w_lane0_start = (r_state == ST_IDLE);
               w_src         = {bus.s_data_i[191:0], w_lane0_start ? START_BLK : r_resid};
               w_tv          = 6'd32;
               w_err         = w_in_err;
               w_nxt_resid   = bus.s_data_i[255:192];
               w_nxt_state   = ST_DATA;
               if (bus.s_last_i) begin
                  if (w_t < 6'd32) begin
                     w_tv        = w_t;
                     w_has_term  = 1'b1;
                     w_nxt_state = ST_IPG;
                     w_nxt_cnt   = IPG_LD;
                  end else begin
                     w_nxt_tail_r   = 4'(w_t - 6'd32);
                     w_nxt_state    = ST_TAIL;
                     w_nxt_err_tail = w_in_err;
                  end
               end
            end
         end
         ST_TAIL: begin
            w_src       = {192'd0, r_resid};
            w_tv        = {2'b00, r_tail_r};
            w_has_term  = 1'b1;
            w_err       = r_err_tail;
            w_nxt_state = ST_IPG;
            w_nxt_cnt   = IPG_LD;
         end
         default: begin
            w_nxt_cnt = r_ipg_cnt - 4'd1;
            if (r_ipg_cnt <= 4'd1) w_nxt_state = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_ctrl_v  = '0;
      w_idle_v  = '0;
      w_start_v = '0;
      w_term_v  = '0;
      w_err_v   = '0;
      w_data    = '0;
      w_keep    = '0;
      w_lkeep   = 8'((9'd1 << w_tv[2:0]) - 9'd1);
      for (int l = 0; l < 4; l++) begin
         if (3'(l) < w_tv[5:3]) begin
            w_ctrl_v[l]        = w_lane0_start && (l == 0);
            w_start_v[l]       = w_lane0_start && (l == 0);
            w_data[64*l +: 64] = w_src[64*l +: 64];
            w_keep[8*l +: 8]   = 8'hFF;
         end else if (w_has_term && (3'(l) == w_tv[5:3])) begin
            w_ctrl_v[l]      = 1'b1;
            w_term_v[l]      = 1'b1;
            w_keep[8*l +: 8] = w_lkeep;
            for (int b = 0; b < 8; b++)
               w_data[64*l+8*b +: 8] = w_src[64*l+8*b +: 8] & {8{w_lkeep[b]}};
         end else begin
            w_ctrl_v[l] = 1'b1;
            w_idle_v[l] = 1'b1;
         end
      end
      if (w_err) begin
         w_ctrl_v = 4'hF;
         w_err_v  = 4'hF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_ipg_cnt  <= '0;
         r_resid    <= '0;
         r_tail_r   <= '0;
         r_err_tail <= 1'b0;
         r_ctrl_v   <= 4'hF;
         r_idle_v   <= 4'hF;
         r_start_v  <= '0;
         r_term_v   <= '0;
         r_err_v    <= '0;
         r_data     <= '0;
         r_keep     <= '0;
      end else if (bus.pcs_ready_i) begin
         r_state    <= w_nxt_state;
         r_ipg_cnt  <= w_nxt_cnt;
         r_resid    <= w_nxt_resid;
         r_tail_r   <= w_nxt_tail_r;
         r_err_tail <= w_nxt_err_tail;
         r_ctrl_v   <= w_ctrl_v;
         r_idle_v   <= w_idle_v;
         r_start_v  <= w_start_v;
         r_term_v   <= w_term_v;
         r_err_v    <= w_err_v;
         r_data     <= w_data;
         r_keep     <= w_keep;
      end
   end

   assign bus.ctrl_v_o  = r_ctrl_v;
   assign bus.idle_v_o  = r_idle_v;
   assign bus.start_v_o = r_start_v;
   assign bus.term_v_o  = r_term_v;
   assign bus.err_v_o   = r_err_v;
   assign bus.data_o    = r_data;
   assign bus.keep_o    = r_keep;
endmodule

// File: tb/tb_mac_tx_fmt.sv
// Random-frame bench for mac_tx_fmt: expected PCS beats come from a flattened byte-stream model of each frame.
module tb_mac_tx_fmt;
   localparam int IPG = 3;

   typedef struct {
      logic [3:0]   ctrl, idle, start, term;
      logic [255:0] dat;
      logic [31:0]  keep;
      int           gap;   // 0 none, 1 at least IPG idle beats before start, 2 exactly IPG
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pcs_mode = 0;
   logic mon_en = 1'b0;
   logic seen_term = 1'b0;
   int   idle_cnt = 0;
   beat_t exp_q[$];
   beat_t mon_e;

   mac_tx_fmt_if bus();

   mac_tx_fmt #(.IPG_BEATS(IPG)) dut (.clk(clk), .reset(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // PCS ready generator: 0 always ready, 1 random, 2 three-on/three-off
   initial begin
      int pc = 0;
      bus.pcs_ready_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         pc++;
         case (pcs_mode)
            0: bus.pcs_ready_i = 1'b1;
            1: bus.pcs_ready_i = ($urandom_range(0, 3) != 0);
            default: bus.pcs_ready_i = ((pc % 6) < 3);
         endcase
      end
   end

   // Each register value is consumed exactly once, in a cycle where pcs_ready_i=1.
   always @(negedge clk) begin
      if (mon_en) begin
         if (!bus.pcs_ready_i) begin
            check_eq("sready_when_stalled", bus.s_ready_o, 0);
         end else if (bus.ctrl_v_o == 4'hF && bus.idle_v_o == 4'hF && bus.start_v_o == 4'h0 &&
                      bus.term_v_o == 4'h0 && bus.err_v_o == 4'h0 && bus.data_o == '0 && bus.keep_o == '0) begin
            idle_cnt++;
         end else if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 256'(exp_q.size()), 256'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("ctrl_v", bus.ctrl_v_o, mon_e.ctrl);
            check_eq("idle_v", bus.idle_v_o, mon_e.idle);
            check_eq("start_v", bus.start_v_o, mon_e.start);
            check_eq("term_v", bus.term_v_o, mon_e.term);
            check_eq("err_v", bus.err_v_o, 4'h0);
            check_eq("data", bus.data_o, mon_e.dat);
            check_eq("keep", bus.keep_o, mon_e.keep);
            if (mon_e.start != 4'h0 && seen_term) begin
               if (mon_e.gap == 2) check_eq("ipg_exact", 256'(idle_cnt), 256'(IPG));
               else if (mon_e.gap == 1) check_eq("ipg_min", 256'(idle_cnt >= IPG), 256'd1);
            end
            if (mon_e.term != 4'h0) begin
               seen_term = 1'b1;
               idle_cnt  = 0;
            end
         end
      end
   end

   task automatic wait_accept();
      int   cyc = 0;
      logic acc = 1'b0;
      while (!acc && cyc < 2000) begin
         @(negedge clk);
         acc = bus.s_ready_o;
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("accept", acc, 1);
   endtask

   task automatic send_frame(input int len, input int gap);
      logic [7:0]   fb[$];
      logic [63:0]  pre;
      logic [255:0] d;
      logic [31:0]  kp;
      beat_t        e;
      int           p, s, n;
      pre = 64'hD5555555555555FB;
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
      // Output byte stream: 8 preamble/SFD bytes, payload, terminate at byte p, 32 bytes per beat.
      p = 8 + len;
      for (int b = 0; b <= p / 32; b++) begin
         e = '{default: '0};
         e.gap = (b == 0) ? gap : 0;
         for (int l = 0; l < 4; l++) begin
            s = 32 * b + 8 * l;
            if (s + 8 <= p) begin
               e.keep[8*l +: 8] = 8'hFF;
               if (s == 0) begin
                  e.ctrl[l] = 1'b1;
                  e.start[l] = 1'b1;
                  e.dat[63:0] = pre;
               end else begin
                  for (int k = 0; k < 8; k++) e.dat[64*l+8*k +: 8] = fb[s+k-8];
               end
            end else if (s <= p) begin
               e.ctrl[l] = 1'b1;
               e.term[l] = 1'b1;
               for (int k = 0; k < p - s; k++) begin
                  e.keep[8*l+k] = 1'b1;
                  e.dat[64*l+8*k +: 8] = fb[s+k-8];
               end
            end else begin
               e.ctrl[l] = 1'b1;
               e.idle[l] = 1'b1;
            end
         end
         exp_q.push_back(e);
      end
      for (int b = 0; 32 * b < len; b++) begin
         n = len - 32 * b;
         if (n > 32) n = 32;
         for (int i = 0; i < 32; i++) begin
            d[8*i +: 8] = (i < n) ? fb[32*b+i] : 8'($urandom);
            kp[i] = (i < n);
         end
         bus.s_valid_i = 1'b1;
         bus.s_data_i  = d;
         bus.s_keep_i  = kp;
         bus.s_last_i  = (32 * (b + 1) >= len);
         wait_accept();
      end
      bus.s_valid_i = 1'b0;
      bus.s_last_i  = 1'b0;
   endtask

   task automatic drain();
      int c = 0;
      while (exp_q.size() != 0 && c < 3000) begin
         @(posedge clk);
         c++;
      end
      check_eq("drain", 256'(exp_q.size()), 256'd0);
      repeat (IPG + 3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = '0;
      bus.s_keep_i  = '0;
      bus.s_last_i  = 1'b0;
`ifdef MAC_TX_FMT_ERR_EN
      bus.s_err_i   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_sready", bus.s_ready_o, 0);
      check_eq("rst_ctrl_v", bus.ctrl_v_o, 4'hF);
      check_eq("rst_idle_v", bus.idle_v_o, 4'hF);
      check_eq("rst_start_v", bus.start_v_o, 4'h0);
      check_eq("rst_term_v", bus.term_v_o, 4'h0);
      check_eq("rst_data", bus.data_o, 0);
      check_eq("rst_keep", bus.keep_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // back-to-back with PCS always ready: exact inter-frame gap
      send_frame(16, 0);
      send_frame(64, 2);
      send_frame(44, 2);
      send_frame(24, 2);
      send_frame(23, 2);
      send_frame(32, 2);
      send_frame(1, 2);
      send_frame(96, 2);

      pcs_mode = 2;
      send_frame(70, 1);
      send_frame(33, 1);
      send_frame(100, 1);

      pcs_mode = 1;
      for (int f = 0; f < 25; f++) begin
         send_frame($urandom_range(1, 130), 1);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
      end
      drain();

      // reset while the second beat of a frame is offered
      pcs_mode = 0;
      mon_en = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = {8{32'($urandom)}};
      bus.s_keep_i  = '1;
      bus.s_last_i  = 1'b0;
      wait_accept();
      bus.s_data_i  = {8{32'($urandom)}};
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_sready", bus.s_ready_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.s_valid_i = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_ctrl_v", bus.ctrl_v_o, 4'hF);
      check_eq("rst_mid_idle_v", bus.idle_v_o, 4'hF);
      check_eq("rst_mid_term_v", bus.term_v_o, 4'h0);
      check_eq("rst_mid_data", bus.data_o, 0);
      check_eq("rst_mid_keep", bus.keep_o, 0);
      check_eq("rst_mid_ready_after", bus.s_ready_o, 1);
      exp_q.delete();
      seen_term = 1'b0;
      idle_cnt = 0;
      mon_en = 1'b1;
      @(posedge clk); #1;
      send_frame(40, 0);
      send_frame(5, 2);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
